alu_status_unit: RTL and testbench
==================================

ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

Interface
REQ-001 Parameter PC_W, 32, program-counter and EPC width.
REQ-002 Parameter ACK_TIMEOUT, 15, max cycles in REQ awaiting exc_ack (legal range 1..255).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 status_in  input  8  ALU status: [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd, [2] div-by-zero, [1:0] reserved.
REQ-006 status_we  input  1  commit strobe; status_in and pc_in valid this cycle.
REQ-007 pc_in  input  PC_W  PC of committing instruction.
REQ-008 ovf_trap_en  input  1  overflow raises exception when 1.
REQ-009 dz_trap_en  input  1  div-by-zero raises exception when 1.
REQ-010 clr_sticky  input  1  clears sticky_out.
REQ-011 exc_ack  input  1  exception handler acknowledge.
REQ-012 flags_out  output  8  last committed flags, bits [1:0] forced 0.
REQ-013 sticky_out  output  8  accumulated flags; [1] = ack-timeout indicator, [0] = 0.
REQ-014 exc_req  output  1  exception request, level.
REQ-015 exc_cause  output  2  00 none, 01 overflow, 10 div-by-zero.
REQ-016 epc_out  output  PC_W  PC of trapping instruction.
REQ-017 stall  output  1  upstream must hold commit while 1.

Function
REQ-018 FSM states IDLE, REQ, DRAIN; all outputs registered.
REQ-019 IDLE, status_we=1: flags_out <= status_in & 8'hFC next cycle.
REQ-020 IDLE, status_we=1: sticky_out[7:2] <= sticky_out[7:2] | status_in[7:2].
REQ-021 Trap condition = status_we & ((status_in[2] & dz_trap_en) | (status_in[6] & ovf_trap_en)), evaluated only in IDLE.
REQ-022 Trap in IDLE: next cycle state=REQ, exc_req=1, stall=1, epc_out=pc_in, exc_cause per REQ-023; flags/sticky still updated per REQ-019/020.
REQ-023 Both trap sources true: exc_cause=10 (div-by-zero has priority).
REQ-024 REQ: exc_req, exc_cause, epc_out held stable until exit.
REQ-025 REQ, exc_ack=1: next cycle state=DRAIN, exc_req=0.
REQ-026 REQ: timeout counter increments each cycle from 0; counter==ACK_TIMEOUT-1 without exc_ack -> DRAIN and sticky_out[1] <= 1.
REQ-027 exc_ack on the same cycle as the timeout point: ack wins, sticky_out[1] unchanged.
REQ-028 DRAIN: stall=1, exc_req=0, exc_cause=00; one cycle, then IDLE with stall=0.
REQ-029 status_we in REQ or DRAIN is ignored entirely (no flag, sticky or EPC update).
REQ-030 exc_ack outside REQ is ignored.
REQ-031 clr_sticky=1 clears sticky_out in any state; same-cycle commit in IDLE: sticky_out[7:2] <= status_in[7:2] (new bits survive clear); same-cycle timeout: sticky_out[1] <= 1.
REQ-032 epc_out retains value after exception until next trap.
REQ-033 Trap with trap enable toggled mid-REQ: no effect on current exception.

Reset
REQ-034 rst_n=0 asynchronously: state=IDLE, flags_out=0, sticky_out=0, exc_req=0, exc_cause=00, epc_out=0, stall=0, counter=0.
REQ-035 Reset mid-REQ abandons exception with no sticky_out[1] set; first commit after rst_n release processed normally.

Structure
REQ-036 Shared package holds status bit index constants, cause encodings and FSM state encoding, reused by the ALU and the control path.
REQ-037 One sub-module natural: exc_ack_timer (loadable down-counter with expiry pulse); the rest is flat.

Verification
REQ-038 Commit status_in=8'h80, pc_in=0x100, traps enabled -> flags_out=0x80, sticky_out=0x80, no exc_req, stall=0.
REQ-039 Commit status_in=8'h44 (ovf+dz), pc_in=0x200, both enables -> exc_req=1, exc_cause=10, epc_out=0x200; exc_ack after 3 cycles -> DRAIN one cycle, IDLE.
REQ-040 Overflow trap, no ack for 15 cycles -> sticky_out[1]=1, DRAIN, IDLE; ack on 15th REQ cycle instead -> sticky_out[1]=0.
REQ-041 Commit during REQ with status_in=8'h10, pc_in=0x300 -> flags_out, sticky_out, epc_out unchanged.
REQ-042 clr_sticky with commit status_in=8'h20 after sticky_out=0xC0 -> sticky_out=0x20.
REQ-043 rst_n low mid-REQ -> all outputs 0 asynchronously; ovf_trap_en=0 with status_in=8'h40 -> sticky_out[6]=1, no exc_req.

Source files
------------

// File: rtl/alu_status_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_status_unit_pkg
// Shared definitions for the ALU status / exception unit.
//   - bit positions of the ALU status byte and of the sticky timeout flag
//   - exception cause encodings
//   - control FSM state encoding
//   - helper that resolves the cause when both trap sources fire
// Imported by the top level so the datapath and the control path agree on
// the same encodings.
// ---------------------------------------------------------------------------
package alu_status_unit_pkg;

  localparam int FLAG_ZERO      = 7;
  localparam int FLAG_OVF       = 6;
  localparam int FLAG_CARRY     = 5;
  localparam int FLAG_NEG       = 4;
  localparam int FLAG_ODD       = 3;
  localparam int FLAG_DZ        = 2;
  localparam int STICKY_TIMEOUT = 1;

  // Bits [1:0] of the status byte are reserved and never reported.
  localparam logic [7:0] FLAG_MASK = 8'hFC;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OVF  = 2'b01,
    CAUSE_DZ   = 2'b10
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Divide-by-zero outranks overflow when both trap sources are active.
  function automatic exc_cause_e trap_cause(input logic dz_hit);
    return dz_hit ? CAUSE_DZ : CAUSE_OVF;
  endfunction

endpackage

// File: rtl/alu_status_unit_if.sv
// ---------------------------------------------------------------------------
// alu_status_unit_if
// Commit bus and exception handshake between the pipeline / handler side
// (master) and the status unit (slave).
//   status_in  [7:0]      ALU status of the committing instruction
//   status_we             commit strobe
//   pc_in      [PC_W-1:0] PC of the committing instruction
//   exc_ack               handler acknowledge
//   exc_req               exception request (level)
//   exc_cause  [1:0]      00 none, 01 overflow, 10 div-by-zero
//   epc_out    [PC_W-1:0] PC of the trapping instruction
// ---------------------------------------------------------------------------
interface alu_status_unit_if #(
  parameter int PC_W = 32
);

  logic [7:0]      status_in;
  logic            status_we;
  logic [PC_W-1:0] pc_in;
  logic            exc_ack;
  logic            exc_req;
  logic [1:0]      exc_cause;
  logic [PC_W-1:0] epc_out;

  modport master (
    output status_in, status_we, pc_in, exc_ack,
    input  exc_req, exc_cause, epc_out
  );

  modport slave (
    input  status_in, status_we, pc_in, exc_ack,
    output exc_req, exc_cause, epc_out
  );

endinterface

// File: rtl/alu_status_unit_exc_ack_timer.sv
// ---------------------------------------------------------------------------
// alu_status_unit_exc_ack_timer
// Loadable down-counter bounding how long an exception request may wait for
// the handler acknowledge.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        reload with ACK_TIMEOUT-1 (asserted on the trap cycle)
//   run         count down while the request is outstanding
//   expired     high on the last permitted request cycle
// Loading ACK_TIMEOUT-1 and expiring at zero is the mirror image of an
// up-counter starting at 0 and expiring at ACK_TIMEOUT-1, so the request
// window is exactly ACK_TIMEOUT cycles long.
// ---------------------------------------------------------------------------
module alu_status_unit_exc_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LOAD_VAL = 8'(ACK_TIMEOUT - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (run && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expired = run && (count_q == 8'd0);

endmodule

// File: rtl/alu_status_unit.sv
// ---------------------------------------------------------------------------
// alu_status_unit
// Captures committed ALU flags, accumulates sticky flags and raises a
// precise exception on overflow / divide-by-zero.
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   commit bus + exception handshake (see alu_status_unit_if)
//   ovf_trap_en   overflow raises an exception when 1
//   dz_trap_en    divide-by-zero raises an exception when 1
//   clr_sticky    clears sticky_out (bits being set in the same cycle win)
//   flags_out     last committed flags, [1:0] = 0
//   sticky_out    accumulated flags, [1] = ack-timeout seen, [0] = 0
//   stall         upstream must hold commit while 1
// Control: IDLE accepts commits; a trap moves to REQ until exc_ack or the
// timeout, then one DRAIN cycle before IDLE. All outputs are registered.
// ---------------------------------------------------------------------------
module alu_status_unit
  import alu_status_unit_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_status_unit_if.slave   bus,
  input  logic               ovf_trap_en,
  input  logic               dz_trap_en,
  input  logic               clr_sticky,
  output logic [7:0]         flags_out,
  output logic [7:0]         sticky_out,
  output logic               stall
);

  state_e          state_q;
  logic [7:0]      flags_q;
  logic [7:0]      sticky_q;
  logic            exc_req_q;
  exc_cause_e      cause_q;
  logic [PC_W-1:0] epc_q;
  logic            stall_q;

  logic dz_hit;
  logic ovf_hit;
  logic trap_hit;
  logic timer_load;
  logic timer_run;
  logic timer_expired;

  assign dz_hit     = bus.status_in[FLAG_DZ] & dz_trap_en;
  assign ovf_hit    = bus.status_in[FLAG_OVF] & ovf_trap_en;
  assign trap_hit   = bus.status_we & (dz_hit | ovf_hit);
  assign timer_load = (state_q == ST_IDLE) && trap_hit;
  assign timer_run  = (state_q == ST_REQ);

  alu_status_unit_exc_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_exc_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Control FSM and all registered outputs. The clr_sticky assignment comes
  // first so that bits set later in the same cycle (a commit in IDLE or a
  // timeout in REQ) override the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flags_q   <= '0;
      sticky_q  <= '0;
      exc_req_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
      epc_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (clr_sticky) begin
        sticky_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.status_we) begin
            flags_q       <= bus.status_in & FLAG_MASK;
            sticky_q[7:2] <= (clr_sticky ? 6'b0 : sticky_q[7:2]) | bus.status_in[7:2];
            if (trap_hit) begin
              state_q   <= ST_REQ;
              exc_req_q <= 1'b1;
              stall_q   <= 1'b1;
              epc_q     <= bus.pc_in;
              cause_q   <= trap_cause(dz_hit);
            end
          end
        end
        ST_REQ: begin
          if (bus.exc_ack || timer_expired) begin
            state_q   <= ST_DRAIN;
            exc_req_q <= 1'b0;
            cause_q   <= CAUSE_NONE;
            if (!bus.exc_ack) begin
              sticky_q[STICKY_TIMEOUT] <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign flags_out     = flags_q;
  assign sticky_out    = sticky_q;
  assign stall         = stall_q;
  assign bus.exc_req   = exc_req_q;
  assign bus.exc_cause = cause_q;
  assign bus.epc_out   = epc_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_status_unit
// Directed, table-driven bench for alu_status_unit. Each vector is applied
// for one clock and the registered outputs are compared 1 ns after the edge.
// Hand-written sequences cover the ack timeout window and mid-request reset.
// ---------------------------------------------------------------------------
module tb_alu_status_unit;

  typedef struct {
    logic [7:0]  st;
    logic        we;
    logic [31:0] pc;
    logic        ovf_en;
    logic        dz_en;
    logic        clr;
    logic        ack;
    logic [7:0]  exp_flags;
    logic [7:0]  exp_sticky;
    logic        exp_req;
    logic [1:0]  exp_cause;
    logic [31:0] exp_epc;
    logic        exp_stall;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       ovf_trap_en;
  logic       dz_trap_en;
  logic       clr_sticky;
  logic [7:0] flags_out;
  logic [7:0] sticky_out;
  logic       stall;

  int checks;
  int errors;

  alu_status_unit_if #(.PC_W(32)) bus ();

  alu_status_unit #(
    .PC_W        (32),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .ovf_trap_en (ovf_trap_en),
    .dz_trap_en  (dz_trap_en),
    .clr_sticky  (clr_sticky),
    .flags_out   (flags_out),
    .sticky_out  (sticky_out),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_field(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_output(input vec_t v, input string tag);
    check_field({tag, ".flags"},  32'(flags_out),     32'(v.exp_flags));
    check_field({tag, ".sticky"}, 32'(sticky_out),    32'(v.exp_sticky));
    check_field({tag, ".req"},    32'(bus.exc_req),   32'(v.exp_req));
    check_field({tag, ".cause"},  32'(bus.exc_cause), 32'(v.exp_cause));
    check_field({tag, ".epc"},    bus.epc_out,        v.exp_epc);
    check_field({tag, ".stall"},  32'(stall),         32'(v.exp_stall));
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.status_in = v.st;
    bus.status_we = v.we;
    bus.pc_in     = v.pc;
    bus.exc_ack   = v.ack;
    ovf_trap_en   = v.ovf_en;
    dz_trap_en    = v.dz_en;
    clr_sticky    = v.clr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] st, input logic we, input logic [31:0] pc,
                              input logic ovf_en, input logic dz_en, input logic clr,
                              input logic ack, input logic [7:0] ef, input logic [7:0] es,
                              input logic er, input logic [1:0] ec, input logic [31:0] ee,
                              input logic est);
    vec_t v;
    v.st = st; v.we = we; v.pc = pc; v.ovf_en = ovf_en; v.dz_en = dz_en;
    v.clr = clr; v.ack = ack; v.exp_flags = ef; v.exp_sticky = es;
    v.exp_req = er; v.exp_cause = ec; v.exp_epc = ee; v.exp_stall = est;
    return v;
  endfunction

  // Waits out the request window that started on the previous edge. The
  // first 14 REQ cycles must keep the request up; the 15th carries the
  // given ack/clr and must land in DRAIN, then IDLE one cycle later.
  task automatic req_window(input logic ack_last, input logic clr_last,
                            input logic [7:0] fl, input logic [7:0] exp_sticky,
                            input logic [1:0] cause, input logic [31:0] epc,
                            input string tag);
    vec_t v;
    for (int i = 0; i < 14; i++) begin
      v = mk(8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
             fl, sticky_out, 1'b1, cause, epc, 1'b1);
      apply_stimulus(v);
      check_field({tag, ".hold_req"}, 32'(bus.exc_req), 32'd1);
    end
    v = mk(8'h00, 1'b0, 32'h0, 1'b1, 1'b1, clr_last, ack_last,
           fl, exp_sticky, 1'b0, 2'b00, epc, 1'b1);
    apply_stimulus(v);
    check_output(v, {tag, ".drain"});
    v = mk(8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
           fl, exp_sticky, 1'b0, 2'b00, epc, 1'b0);
    apply_stimulus(v);
    check_output(v, {tag, ".idle"});
  endtask

  vec_t vecs[19];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.status_in = '0; bus.status_we = 1'b0; bus.pc_in = '0; bus.exc_ack = 1'b0;
    ovf_trap_en = 1'b0; dz_trap_en = 1'b0; clr_sticky = 1'b0;

    //              st     we    pc        ovf   dz    clr   ack   flags  sticky req   cause  epc       stall
    vecs[0]  = mk(8'h80, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 2'b00, 32'h000, 1'b0);
    vecs[1]  = mk(8'h44, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'hC4, 1'b1, 2'b10, 32'h200, 1'b1);
    vecs[2]  = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'hC4, 1'b1, 2'b10, 32'h200, 1'b1);
    vecs[3]  = mk(8'h10, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'hC4, 1'b1, 2'b10, 32'h200, 1'b1);
    vecs[4]  = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'hC4, 1'b0, 2'b00, 32'h200, 1'b1);
    vecs[5]  = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'hC4, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[6]  = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'hC4, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[7]  = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[8]  = mk(8'hC0, 1'b1, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'hC0, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[9]  = mk(8'h20, 1'b1, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h20, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[10] = mk(8'h40, 1'b1, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h60, 1'b0, 2'b00, 32'h200, 1'b0);
    vecs[11] = mk(8'h48, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48, 8'h68, 1'b1, 2'b01, 32'h400, 1'b1);
    vecs[12] = mk(8'h00, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h48, 8'h00, 1'b1, 2'b01, 32'h400, 1'b1);
    vecs[13] = mk(8'h00, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h48, 8'h00, 1'b0, 2'b00, 32'h400, 1'b1);
    vecs[14] = mk(8'h04, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48, 8'h00, 1'b0, 2'b00, 32'h400, 1'b0);
    vecs[15] = mk(8'h04, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h04, 1'b1, 2'b10, 32'h500, 1'b1);
    vecs[16] = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 8'h04, 1'b0, 2'b00, 32'h500, 1'b1);
    vecs[17] = mk(8'h00, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 2'b00, 32'h500, 1'b0);
    vecs[18] = mk(8'h04, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 2'b00, 32'h500, 1'b0);

    // Reset: asynchronous assertion, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    v = mk(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 32'h0, 1'b0);
    check_output(v, "reset");
    apply_stimulus(v);
    apply_stimulus(v);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], $sformatf("vec%0d", i));
    end

    // Full timeout: no ack for 15 REQ cycles sets sticky[1].
    v = mk(8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 2'b00, 32'h500, 1'b0);
    apply_stimulus(v);
    check_output(v, "tmo.clr");
    v = mk(8'h40, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 1'b1, 2'b01, 32'h600, 1'b1);
    apply_stimulus(v);
    check_output(v, "tmo.trap");
    req_window(1'b0, 1'b0, 8'h40, 8'h42, 2'b01, 32'h600, "tmo");

    // Timeout coinciding with clr_sticky: only the timeout bit survives.
    v = mk(8'h40, 1'b1, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h42, 1'b1, 2'b01, 32'h700, 1'b1);
    apply_stimulus(v);
    check_output(v, "tmoclr.trap");
    req_window(1'b0, 1'b1, 8'h40, 8'h02, 2'b01, 32'h700, "tmoclr");

    // Ack on the 15th REQ cycle beats the timeout.
    v = mk(8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 2'b00, 32'h700, 1'b0);
    apply_stimulus(v);
    v = mk(8'h40, 1'b1, 32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 1'b1, 2'b01, 32'h800, 1'b1);
    apply_stimulus(v);
    check_output(v, "ack15.trap");
    req_window(1'b1, 1'b0, 8'h40, 8'h40, 2'b01, 32'h800, "ack15");

    // Reset in the middle of a request abandons it without a timeout mark.
    v = mk(8'h44, 1'b1, 32'h900, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h44, 1'b1, 2'b10, 32'h900, 1'b1);
    apply_stimulus(v);
    check_output(v, "rstreq.trap");
    #2 rst_n = 1'b0;
    #1;
    v = mk(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 32'h0, 1'b0);
    check_output(v, "rstreq.async");
    apply_stimulus(v);
    rst_n = 1'b1;
    v = mk(8'h40, 1'b1, 32'hA00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 2'b00, 32'h0, 1'b0);
    apply_stimulus(v);
    check_output(v, "rstreq.first");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
